bcd_serial_addsub: RTL



---
 rtl/bcd_serial_addsub.sv | 103 ++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD adder/subtractor, one digit per clock, LSD first.
// Define BCD_DIGIT_CHECK_EN to reject operands containing a nibble above 9 (err output).
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [W-1:0] a_r, b_r, work, work_n;
  logic [IW-1:0] idx;
  logic sub_r, carry, skip, last;
  logic [3:0] a_d, b_d, b_p, digit;
  logic [4:0] t;
  assign ready = state == IDLE && !rst;
  assign last = idx == LAST;
  always_comb begin
    a_d = a_r[4*idx +: 4];
    b_d = b_r[4*idx +: 4];
    b_p = sub_r ? 4'd9 - b_d : b_d;
    t = 5'(a_d) + 5'(b_p) + 5'(carry);
    digit = t > 5'd9 ? t[3:0] - 4'd10 : t[3:0];
    work_n = work;
    work_n[4*idx +: 4] = digit;
  end
`ifdef BCD_DIGIT_CHECK_EN
  logic bad_in, bad_r;
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad_in = bad_in | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
  end
  // err changes only when an operation completes, valid or rejected
  always_ff @(posedge clk)
    if (rst) begin
      bad_r <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && start) bad_r <= bad_in;
      if (state == CALC && (bad_r || last)) err <= bad_r;
    end
  assign skip = bad_r;
`else
  assign skip = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      work <= '0;
      sum <= '0;
      idx <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      cout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          sub_r <= sub;
          carry <= cin;
          idx <= '0;
          state <= CALC;
        end
        CALC: if (skip) begin
          sum <= '0;
          cout <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end else begin
          work <= work_n;
          carry <= t > 5'd9;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            sum <= work_n;
            cout <= t > 5'd9;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
